// File: rtl/rgmii_rx_ctrl_pkg.sv
// rtl/rgmii_rx_ctrl_pkg.sv - shared constants and FSM encoding for the RGMII receive sequencer
package rgmii_rx_ctrl_pkg;

  localparam logic [7:0] RGMII_PREAMBLE = 8'h55;
  localparam logic [7:0] RGMII_SFD      = 8'hD5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_PAYLOAD  = 2'd2,
    ST_DROP     = 2'd3
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - event counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc_i,
  output logic [CNT_WIDTH-1:0] count_o
);

  logic [CNT_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/rgmii_rx_ctrl.sv
// rtl/rgmii_rx_ctrl.sv - RGMII receive byte reassembly, preamble/SFD strip and frame delimiting
module rgmii_rx_ctrl
  import rgmii_rx_ctrl_pkg::*;
#(
  parameter int MAX_LEN   = 1522,
  parameter int CNT_WIDTH = 32,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           rxd_q1,
  input  logic [3:0]           rxd_q2,
  input  logic                 rx_ctl_q1,
  input  logic                 rx_ctl_q2,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  output logic [CNT_WIDTH-1:0] frame_cnt,
  output logic [CNT_WIDTH-1:0] bad_cnt,
  output logic                 busy
);

  logic [7:0]           s0_data_q;
  logic                 s0_dv_q, s0_er_q;
  state_e               state_q, state_d;
  logic [7:0]           hold_q, hold_d;
  logic                 hold_vld_q, hold_vld_d;
  logic                 err_q, err_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [7:0]           tdata_q, tdata_d;
  logic                 tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
  logic                 good_inc, bad_inc;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    err_d      = err_q;
    len_d      = len_q;
    tdata_d    = tdata_q;
    tvalid_d   = 1'b0;
    tlast_d    = 1'b0;
    tuser_d    = 1'b0;
    good_inc   = 1'b0;
    bad_inc    = 1'b0;

    case (state_q)
      ST_IDLE, ST_PREAMBLE: begin
        if (!s0_dv_q) begin
          state_d = ST_IDLE;
        end else if (s0_data_q == RGMII_PREAMBLE) begin
          state_d = ST_PREAMBLE;
        end else if (s0_data_q == RGMII_SFD) begin
          state_d    = ST_PAYLOAD;
          err_d      = 1'b0;
          len_d      = '0;
          hold_vld_d = 1'b0;
        end else begin
          state_d = ST_DROP;
        end
      end

      ST_PAYLOAD: begin
        if (s0_dv_q) begin
          if (len_q == LEN_WIDTH'(MAX_LEN)) begin
            // Oversized: close the frame on the byte already held, discard the rest.
            tdata_d    = hold_q;
            tvalid_d   = 1'b1;
            tlast_d    = 1'b1;
            tuser_d    = 1'b1;
            bad_inc    = 1'b1;
            hold_vld_d = 1'b0;
            state_d    = ST_DROP;
          end else begin
            if (hold_vld_q) begin
              tdata_d  = hold_q;
              tvalid_d = 1'b1;
            end
            hold_d     = s0_data_q;
            hold_vld_d = 1'b1;
            len_d      = len_q + LEN_WIDTH'(1);
            if (s0_er_q) begin
              err_d = 1'b1;
            end
          end
        end else begin
          // The one-byte hold lets tlast ride on the final byte rather than a later beat.
          if (hold_vld_q) begin
            tdata_d  = hold_q;
            tvalid_d = 1'b1;
            tlast_d  = 1'b1;
            tuser_d  = err_q;
            good_inc = !err_q;
            bad_inc  = err_q;
          end else begin
            bad_inc = 1'b1;
          end
          hold_vld_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end

      ST_DROP: begin
        if (!s0_dv_q) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_data_q  <= '0;
      s0_dv_q    <= 1'b0;
      s0_er_q    <= 1'b0;
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      err_q      <= 1'b0;
      len_q      <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tuser_q    <= 1'b0;
    end else begin
      s0_data_q  <= {rxd_q2, rxd_q1};
      s0_dv_q    <= rx_ctl_q1;
      s0_er_q    <= rx_ctl_q1 ^ rx_ctl_q2;
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      err_q      <= err_d;
      len_q      <= len_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tuser_q    <= tuser_d;
    end
  end

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_good_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (good_inc),
    .count_o (frame_cnt)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_bad_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (bad_inc),
    .count_o (bad_cnt)
  );

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign busy          = (state_q != ST_IDLE);

endmodule
